// File: rtl/oam_dma_controller_if.sv
// rtl/oam_dma_controller_if.sv - CPU bus / OAM port signal bundle for the sprite DMA engine
interface oam_dma_controller_if;
    logic        clock_EN;
    logic        regWrite_EN;
    logic [7:0]  cpuData_IN;
    logic        cpuReadCycle;
    logic [7:0]  busData_IN;
    logic        cpuHalt;
    logic        dmaRead;
    logic [15:0] dmaAddress;
    logic        oamWrite;
    logic [7:0]  oamData_OUT;
    logic        dmaActive;

    // CPU-side bus decode and memory drive the requests and read data
    modport master (
        output clock_EN, regWrite_EN, cpuData_IN, cpuReadCycle, busData_IN,
        input  cpuHalt, dmaRead, dmaAddress, oamWrite, oamData_OUT, dmaActive
    );

    // the DMA engine consumes requests and owns halt, bus read and OAM write
    modport slave (
        input  clock_EN, regWrite_EN, cpuData_IN, cpuReadCycle, busData_IN,
        output cpuHalt, dmaRead, dmaAddress, oamWrite, oamData_OUT, dmaActive
    );
endinterface

// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - $4014 sprite DMA: halts the CPU and copies page P into OAM (option macro OAM_DMA_ALIGN_EN)
module oam_dma_controller #(
    parameter int PAGE_BYTES = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    oam_dma_controller_if.slave   bus
);
    localparam logic [7:0] LAST_INDEX = 8'(PAGE_BYTES - 1);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {IDLE, HALT_WAIT, ALIGN, READ, WRITE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HALT_WAIT, READ, WRITE} state_t;
`endif

    state_t     state;
    logic [7:0] page;
    logic [7:0] index;
`ifdef OAM_DMA_ALIGN_EN
    // 0 = get (read) cycle, 1 = put (write) cycle; runs freely regardless of state
    logic       parity;
`endif

    // transfer sequencer; outputs are registered alongside the state they belong to
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            page            <= 8'd0;
            index           <= 8'd0;
`ifdef OAM_DMA_ALIGN_EN
            parity          <= 1'b0;
`endif
            bus.cpuHalt     <= 1'b0;
            bus.dmaRead     <= 1'b0;
            bus.dmaAddress  <= 16'd0;
            bus.oamWrite    <= 1'b0;
            bus.oamData_OUT <= 8'd0;
            bus.dmaActive   <= 1'b0;
        end else if (bus.clock_EN) begin
`ifdef OAM_DMA_ALIGN_EN
            parity <= ~parity;
`endif
            case (state)
                IDLE: begin
                    if (bus.regWrite_EN) begin
                        page          <= bus.cpuData_IN;
                        index         <= 8'd0;
                        state         <= HALT_WAIT;
                        bus.cpuHalt   <= 1'b1;
                        bus.dmaActive <= 1'b1;
                    end
                end
                HALT_WAIT: begin
                    // the halt only lands on a CPU read cycle; that cycle is the dummy
                    if (bus.cpuReadCycle) begin
`ifdef OAM_DMA_ALIGN_EN
                        if (!parity) begin
                            // dummy fell on a get: burn one cycle so reads land on gets
                            state <= ALIGN;
                        end else begin
                            state          <= READ;
                            bus.dmaRead    <= 1'b1;
                            bus.dmaAddress <= {page, index};
                        end
`else
                        state          <= READ;
                        bus.dmaRead    <= 1'b1;
                        bus.dmaAddress <= {page, index};
`endif
                    end
                end
`ifdef OAM_DMA_ALIGN_EN
                ALIGN: begin
                    state          <= READ;
                    bus.dmaRead    <= 1'b1;
                    bus.dmaAddress <= {page, index};
                end
`endif
                READ: begin
                    // read data is captured straight into the OAM data register
                    state           <= WRITE;
                    bus.dmaRead     <= 1'b0;
                    bus.dmaAddress  <= 16'd0;
                    bus.oamWrite    <= 1'b1;
                    bus.oamData_OUT <= bus.busData_IN;
                end
                WRITE: begin
                    index           <= index + 8'd1;
                    bus.oamWrite    <= 1'b0;
                    bus.oamData_OUT <= 8'd0;
                    if (index == LAST_INDEX) begin
                        state         <= IDLE;
                        bus.cpuHalt   <= 1'b0;
                        bus.dmaActive <= 1'b0;
                    end else begin
                        state          <= READ;
                        bus.dmaRead    <= 1'b1;
                        bus.dmaAddress <= {page, index + 8'd1};
                    end
                end
                default: begin
                    state           <= IDLE;
                    bus.cpuHalt     <= 1'b0;
                    bus.dmaRead     <= 1'b0;
                    bus.dmaAddress  <= 16'd0;
                    bus.oamWrite    <= 1'b0;
                    bus.oamData_OUT <= 8'd0;
                    bus.dmaActive   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sprite-memory DMA engine for the NES PPU drop-in. It sits between the CPU bus decode and the OAM data port ($2004) of the sprite handler. A CPU write to $4014 with page value P halts the CPU and copies 256 bytes from CPU addresses $P00–$PFF into OAM through the same write path the CPU uses. Cycle counts are NES-accurate: 513 or 514 CPU cycles, depending on get/put parity.

## Interface
Parameters:
- PAGE_BYTES, 256, bytes copied per transfer; the index counter is 8 bits wide.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; returns the block to IDLE
- clock_EN  in  1  CPU-cycle enable; all state advances only when this is high
- regWrite_EN  in  1  CPU is writing $4014 in this CPU cycle
- cpuData_IN  in  8  CPU write data (page number P)
- cpuReadCycle  in  1  the CPU's current cycle is a read; a halt can land only on a read cycle
- busData_IN  in  8  CPU-bus read data returned for dmaAddress
- cpuHalt  out  1  drives the CPU RDY line low (halt)
- dmaRead  out  1  DMA owns the bus and reads dmaAddress
- dmaAddress  out  16  {page, index}
- oamWrite  out  1  write strobe to the OAM data port
- oamData_OUT  out  8  byte to write into OAM
- dmaActive  out  1  high in every state except IDLE

## Operation
- A parity bit toggles on every clock_EN and is independent of state. Parity 0 is a get (read) cycle; parity 1 is a put (write) cycle.
- Outputs are Moore outputs decoded from the registered state.
- States and transitions:
  - IDLE: all outputs 0. If regWrite_EN is high, latch page <= cpuData_IN, clear index to 0, and go to HALT_WAIT.
  - HALT_WAIT: cpuHalt=1. On a cycle with cpuReadCycle=1, this cycle is the dummy (halted) cycle. If its parity is 1 (put), go to READ. If its parity is 0 (get), go to ALIGN. Otherwise stay in HALT_WAIT.
  - ALIGN: cpuHalt=1; go to READ.
  - READ: cpuHalt=1, dmaRead=1, dmaAddress={page,index}. Capture busData_IN into the data register at the end of the cycle; go to WRITE.
  - WRITE: cpuHalt=1, oamWrite=1, oamData_OUT=data register. Then index <= index+1. If index was 255, go to IDLE; otherwise go to READ.
- OAM addressing belongs to the sprite block's OAMADDR auto-increment. This block never drives an OAM address, so a transfer starts at the current OAMADDR and wraps through it.
- An index of 255 increments to 0, wrapping at completion. No extra cycle is spent.
- regWrite_EN is ignored in every state except IDLE.
- Reset mid-transfer: immediate return to IDLE; all outputs, page, index, data register and parity become 0. A partial OAM update is left as written.
- When clock_EN is low, state and outputs hold. Consumers qualify oamWrite and dmaRead with clock_EN.

## Timing
- Reset values: cpuHalt=0, dmaRead=0, dmaAddress=0, oamWrite=0, oamData_OUT=0, dmaActive=0.
- A $4014 write in enabled cycle N gives cpuHalt=1 and dmaActive=1 from cycle N+1.
- Cycle counts from the halt (dummy) cycle to the last WRITE, inclusive:
  - Dummy on a put cycle: 1 + 512 = 513 cycles.
  - Dummy on a get cycle: 1 + 1 + 512 = 514 cycles.
- HALT_WAIT extends by one cycle for each enabled cycle that has cpuReadCycle=0.
- READ always falls on parity 0 and WRITE always on parity 1.
- cpuHalt deasserts in the enabled cycle after the final WRITE.
- Read-to-OAM latency: a byte read in cycle k is written in cycle k+1.

## Configuration
- OAM_DMA_ALIGN_EN:
  - Defined: the ALIGN state is compiled in and the parity rule above applies, giving 513 or 514 cycles.
  - Undefined: ALIGN is removed and HALT_WAIT always goes to READ, so every transfer takes 513 cycles. In this mode READ/WRITE parity is not guaranteed, and the parity bit may be optimized away.

## Test plan
- Page $02 write, bus returns the low address byte; dummy on a put cycle -> 256 oamWrite pulses carrying 00..FF, cpuHalt high for exactly 513 enabled cycles, dmaAddress runs $0200..$02FF.
- Same transfer with the dummy on a get cycle and the macro defined -> one ALIGN cycle, 514 cycles, first dmaRead on parity 0.
- cpuReadCycle held 0 for 3 cycles after the $4014 write -> HALT_WAIT for those 3 cycles, then the normal sequence; the total is the 513/514 figure plus 3.
- Second $4014 write (page $07) at transfer index 40 -> ignored; dmaAddress stays on page $02 and the count is unchanged.
- Reset asserted at index 100 during WRITE -> all outputs 0 on the same edge; a following $4014 write restarts at index 0.
- clock_EN toggling 1-of-3 during a transfer -> the same byte sequence and the same enabled-cycle counts, and no oamWrite is ever sampled while clock_EN is low.
